// File: rtl/ovr_i_pkg.sv
// Shared definitions for the over-current monitor: state encoding and default thresholds.
package ovr_i_pkg;

  localparam int unsigned TRIP_PERIODS_DEF    = 4;
  localparam int unsigned HARD_CYCLES_DEF     = 32;
  localparam int unsigned HOLDOFF_PERIODS_DEF = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_TRIPPED  = 2'd1,
    ST_HOLDOFF  = 2'd2
  } ovr_state_t;

endpackage

// File: rtl/ovr_synch.sv
// Two-flop synchronizer for an asynchronous over-current flag.
module ovr_synch (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; both cleared by reset so no stale flag survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/ovr_i_mon.sv
// Over-current monitor: qualifies driver flags against blanking, trips on
// persistent per-period or sustained per-cycle over-current, re-arms via clr + holdoff.
module ovr_i_mon
  import ovr_i_pkg::*;
#(
  parameter int unsigned TRIP_PERIODS    = TRIP_PERIODS_DEF,
  parameter int unsigned HARD_CYCLES     = HARD_CYCLES_DEF,
  parameter int unsigned HOLDOFF_PERIODS = HOLDOFF_PERIODS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PWM_synch,
  input  logic       ovr_I_blank,
  input  logic       OVR_I_lft,
  input  logic       OVR_I_rght,
  input  logic       clr,
  output logic       OVR_I_shtdwn,
  output logic [1:0] ovr_src
);

  localparam int unsigned PW = $clog2(TRIP_PERIODS + 1);
  localparam int unsigned HW = $clog2(HARD_CYCLES + 1);
  localparam int unsigned OW = $clog2(HOLDOFF_PERIODS + 1);

  logic          lft_s;
  logic          rght_s;
  logic [1:0]    qual_c;
  logic          q_any_c;

  ovr_state_t    state_q,    state_d;
  logic [PW-1:0] per_cnt_q,  per_cnt_d;
  logic [HW-1:0] hard_cnt_q, hard_cnt_d;
  logic [OW-1:0] hold_cnt_q, hold_cnt_d;
  logic          flag_q,     flag_d;
  logic [1:0]    sticky_q,   sticky_d;
  logic          shtdwn_q,   shtdwn_d;
  logic [1:0]    src_q,      src_d;
  logic [OW-1:0] hold_inc_c;

  ovr_synch u_synch_lft (
    .clk     (clk),
    .rst     (rst),
    .async_i (OVR_I_lft),
    .sync_o  (lft_s)
  );

  ovr_synch u_synch_rght (
    .clk     (clk),
    .rst     (rst),
    .async_i (OVR_I_rght),
    .sync_o  (rght_s)
  );

  // Blanking is a locally generated, already-synchronous signal, so it gates directly.
  assign qual_c     = {rght_s & ~ovr_I_blank, lft_s & ~ovr_I_blank};
  assign q_any_c    = |qual_c;
  assign hold_inc_c = hold_cnt_q + OW'(1);

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    hard_cnt_d = hard_cnt_q;
    hold_cnt_d = hold_cnt_q;
    flag_d     = flag_q;
    sticky_d   = sticky_q;
    shtdwn_d   = shtdwn_q;
    src_d      = src_q;

    case (state_q)
      ST_RUN: begin
        sticky_d = sticky_q | qual_c;

        if (q_any_c) begin
          hard_cnt_d = (hard_cnt_q == HW'(HARD_CYCLES)) ? hard_cnt_q : hard_cnt_q + HW'(1);
        end else begin
          hard_cnt_d = '0;
        end

        // Period boundary: a sample in the boundary cycle still belongs to the closing period.
        if (PWM_synch) begin
          flag_d = 1'b0;
          if (flag_q || q_any_c) begin
            per_cnt_d = (per_cnt_q == PW'(TRIP_PERIODS)) ? per_cnt_q : per_cnt_q + PW'(1);
          end else begin
            per_cnt_d = '0;
            sticky_d  = 2'b00;
          end
        end else if (q_any_c) begin
          flag_d = 1'b1;
        end

        // Hard path trips once the registered count shows HARD_CYCLES qualified cycles,
        // giving sync(2) + count + register latency from the raw flag edge.
        if ((per_cnt_d == PW'(TRIP_PERIODS)) || (hard_cnt_q == HW'(HARD_CYCLES))) begin
          state_d  = ST_TRIPPED;
          shtdwn_d = 1'b1;
          src_d    = sticky_d;
        end
      end

      ST_TRIPPED: begin
        if (clr && !lft_s && !rght_s) begin
          state_d    = ST_HOLDOFF;
          hold_cnt_d = '0;
        end
      end

      ST_HOLDOFF: begin
        if (q_any_c) begin
          state_d = ST_TRIPPED;
          src_d   = qual_c;
        end else if (PWM_synch) begin
          if (hold_inc_c >= OW'(HOLDOFF_PERIODS)) begin
            state_d    = ST_RUN;
            shtdwn_d   = 1'b0;
            src_d      = 2'b00;
            per_cnt_d  = '0;
            hard_cnt_d = '0;
            hold_cnt_d = '0;
            flag_d     = 1'b0;
            sticky_d   = 2'b00;
          end else begin
            hold_cnt_d = hold_inc_c;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, counters and outputs; reset discards all trip history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      per_cnt_q  <= '0;
      hard_cnt_q <= '0;
      hold_cnt_q <= '0;
      flag_q     <= 1'b0;
      sticky_q   <= 2'b00;
      shtdwn_q   <= 1'b0;
      src_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      hard_cnt_q <= hard_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      flag_q     <= flag_d;
      sticky_q   <= sticky_d;
      shtdwn_q   <= shtdwn_d;
      src_q      <= src_d;
    end
  end

  assign OVR_I_shtdwn = shtdwn_q;
  assign ovr_src      = src_q;

endmodule

// File: tb/tb_ovr_i_mon.sv
// Scoreboard bench for ovr_i_mon: stimulus pushes expected outputs keyed by cycle,
// a negedge monitor pops and compares them.
module tb_ovr_i_mon;

  localparam int PER = 100;  // PWM period in clk cycles
  localparam int BLK = 56;   // blanking covers phases 0..BLK-1

  logic       clk;
  logic       rst;
  logic       PWM_synch;
  logic       ovr_I_blank;
  logic       OVR_I_lft;
  logic       OVR_I_rght;
  logic       clr;
  logic       OVR_I_shtdwn;
  logic [1:0] ovr_src;

  ovr_i_mon dut (
    .clk          (clk),
    .rst          (rst),
    .PWM_synch    (PWM_synch),
    .ovr_I_blank  (ovr_I_blank),
    .OVR_I_lft    (OVR_I_lft),
    .OVR_I_rght   (OVR_I_rght),
    .clr          (clr),
    .OVR_I_shtdwn (OVR_I_shtdwn),
    .ovr_src      (ovr_src)
  );

  typedef struct {
    int         cyc;
    logic       sh;
    logic [1:0] src;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   ph;
  logic blank_en;
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic sh, input logic [1:0] src,
                     input logic esh, input logic [1:0] esrc);
    n_vec++;
    if (sh !== esh || src !== esrc) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got shtdwn=%0b src=%02b, want shtdwn=%0b src=%02b",
               nm, cyc, sh, src, esh, esrc);
    end
  endtask

  // Monitor: compare every expectation due this cycle; overdue ones are failures.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        cmp(sb[i].name, OVR_I_shtdwn, ovr_src, sb[i].sh, sb[i].src);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: expectation for cyc %0d never checked", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  function automatic void push(input int c, input logic sh, input logic [1:0] s, input string nm);
    exp_t e;
    e.cyc  = c;
    e.sh   = sh;
    e.src  = s;
    e.name = nm;
    sb.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ph          = (ph == PER - 1) ? 0 : ph + 1;
    PWM_synch   = (ph == 0);
    ovr_I_blank = blank_en && (ph < BLK);
  endtask

  task automatic to_period_end();
    while (ph != PER - 1) step();
  endtask

  task automatic run_periods(input int n, input int l_lo, input int l_hi,
                             input int r_lo, input int r_hi);
    for (int p = 0; p < n; p++) begin
      for (int j = 0; j < PER; j++) begin
        step();
        OVR_I_lft  = (ph >= l_lo) && (ph <= l_hi);
        OVR_I_rght = (ph >= r_lo) && (ph <= r_hi);
        if (ph == PER - 1) push(cyc, 1'b0, 2'b00, "period_no_trip");
      end
    end
    OVR_I_lft  = 1'b0;
    OVR_I_rght = 1'b0;
  endtask

  task automatic pulse_clr();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic wait_pulses(input int n);
    int np;
    np = 0;
    while (np < n) begin
      step();
      if (PWM_synch) np++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    int k;
    cyc         = 0;
    ph          = PER - 1;
    blank_en    = 1'b1;
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    PWM_synch   = 1'b0;
    ovr_I_blank = 1'b0;
    OVR_I_lft   = 1'b0;
    OVR_I_rght  = 1'b0;
    clr         = 1'b0;

    push(1, 1'b0, 2'b00, "reset_state");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Left flag only inside blanking: never qualifies.
    run_periods(10, 3, 47, 1, 0);

    // 3-cycle unblanked left pulses in 4 periods: trip right after the 4th evaluation.
    run_periods(4, 60, 62, 1, 0);
    step();
    k = cyc;
    push(k,     1'b0, 2'b00, "period_trip_pre");
    push(k + 1, 1'b1, 2'b01, "period_trip");

    // clr while left flag still high is ignored and not remembered.
    OVR_I_lft = 1'b1;
    repeat (4) step();
    pulse_clr();
    for (int i = 0; i < 5; i++) begin
      step();
      push(cyc, 1'b1, 2'b01, "clr_ignored");
    end
    OVR_I_lft = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      push(cyc, 1'b1, 2'b01, "clr_not_held");
    end

    // Accepted clr: shutdown held for exactly 8 periods, then released with src cleared.
    pulse_clr();
    wait_pulses(8);
    k = cyc;
    push(k,     1'b1, 2'b01, "holdoff_hold");
    push(k + 1, 1'b0, 2'b00, "holdoff_exit");

    // 3 qualified, 1 clean, 3 qualified, 1 clean: counter restarts, no trip.
    to_period_end();
    for (int blk = 0; blk < 2; blk++) begin
      run_periods(3, 60, 62, 1, 0);
      run_periods(1, 1, 0, 1, 0);
    end

    // Right flag held 45 cycles with blanking off: hard trip 2+32+1 cycles after the edge.
    blank_en = 1'b0;
    step();
    OVR_I_rght = 1'b1;
    r = cyc;
    push(r + 34, 1'b0, 2'b00, "hard_trip_pre");
    push(r + 35, 1'b1, 2'b10, "hard_trip");
    repeat (44) step();
    OVR_I_rght = 1'b0;
    blank_en   = 1'b1;

    // Qualified sample during holdoff re-trips and reloads the source.
    repeat (3) step();
    pulse_clr();
    while (ph != 59) step();
    step();
    OVR_I_lft = 1'b1;
    r = cyc;
    push(r + 2, 1'b1, 2'b10, "holdoff_retrip_pre");
    push(r + 3, 1'b1, 2'b01, "holdoff_retrip");
    repeat (3) step();
    OVR_I_lft = 1'b0;

    // Reset in the middle of holdoff clears outputs without a clock edge.
    repeat (3) step();
    pulse_clr();
    wait_pulses(2);
    #2;
    cmp("holdoff_before_rst", OVR_I_shtdwn, ovr_src, 1'b1, 2'b01);
    rst = 1'b1;
    #1;
    cmp("rst_async", OVR_I_shtdwn, ovr_src, 1'b0, 2'b00);
    repeat (2) step();
    rst = 1'b0;

    // History discarded: 3 qualified periods after reset do not trip.
    to_period_end();
    run_periods(3, 60, 62, 1, 0);
    run_periods(1, 1, 0, 1, 0);
    repeat (3) step();
    repeat (2) @(negedge clk);

    while (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: expectation for cyc %0d left unchecked", sb[0].name, sb[0].cyc);
      sb.delete(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ovr_i_mon.md
OVR_I_MON -- requirements
Module: ovr_i_mon

Interface
REQ-001 SHALL have parameter TRIP_PERIODS, default 4: consecutive PWM periods with qualified over-current that cause a trip.
REQ-002 SHALL have parameter HARD_CYCLES, default 32: consecutive qualified clk cycles that cause an immediate trip.
REQ-003 SHALL have parameter HOLDOFF_PERIODS, default 8: PWM periods that shutdown stays asserted after clr is accepted.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port PWM_synch  input  1  single-cycle pulse marking the start of each PWM period.
REQ-007 SHALL have port ovr_I_blank  input  1  high during the switching-transient blanking window.
REQ-008 SHALL have port OVR_I_lft  input  1  asynchronous left-driver over-current flag.
REQ-009 SHALL have port OVR_I_rght  input  1  asynchronous right-driver over-current flag.
REQ-010 SHALL have port clr  input  1  single-cycle request to re-arm after a trip.
REQ-011 SHALL have port OVR_I_shtdwn  output  1  registered; high forces all PWM outputs low.
REQ-012 SHALL have port ovr_src  output  2  registered; bit0 = left and bit1 = right contributed to the trip.

Function
REQ-013 SHALL pass each OVR_I input through a two-flop synchronizer. Qualified sample = synchronized flag AND NOT ovr_I_blank; ovr_I_blank is used unsynchronized.
REQ-014 SHALL implement states RUN, TRIPPED, HOLDOFF.
REQ-015 SHALL, in RUN, set a period flag on any qualified sample (either side).
REQ-016 SHALL evaluate the period at each PWM_synch cycle, using (period flag OR qualified sample in that cycle):
- if set, increment the period counter, saturating at TRIP_PERIODS;
- else clear the counter and the per-side sticky bits.
- The flag clears in the same cycle.
REQ-017 SHALL count consecutive qualified cycles in a hard counter, saturating at HARD_CYCLES. Any unqualified cycle, including a blanked one, clears it.
REQ-018 SHALL set per-side sticky bits on each qualified sample while in RUN.
REQ-019 SHALL trip from RUN to TRIPPED when either condition is met:
- the period counter reaches TRIP_PERIODS;
- the hard counter reaches HARD_CYCLES.
On the trip cycle, OVR_I_shtdwn is registered high and ovr_src latches the sticky bits, including any set in that cycle. Both become visible the next cycle.
REQ-020 SHALL, in TRIPPED, hold OVR_I_shtdwn high and ovr_src frozen, and ignore PWM_synch and further over-current.
REQ-021 SHALL accept clr in TRIPPED only when both synchronized flags are low. An ignored clr is not remembered.
REQ-022 SHALL, on accepting clr, enter HOLDOFF and zero a holdoff counter. That counter increments on each PWM_synch.
REQ-023 SHALL return from HOLDOFF to RUN after HOLDOFF_PERIODS PWM_synch pulses. On that transition it deasserts OVR_I_shtdwn, clears ovr_src and clears all counters and flags.
REQ-024 SHALL return from HOLDOFF to TRIPPED on any qualified sample. It reloads ovr_src with that sample's sides.
REQ-025 SHALL treat clr in RUN or HOLDOFF as a no-op.
REQ-026 SHALL size all counters to $clog2(param+1) bits. Counters never wrap.

Reset
REQ-027 SHALL, on rst high, immediately set the following regardless of clk:
- state = RUN;
- OVR_I_shtdwn = 0, ovr_src = 0;
- all counters, flags and synchronizer flops = 0.
REQ-028 SHALL start evaluation at the first PWM_synch after rst falls. A partial first period counts normally.
REQ-029 SHALL discard all trip history on a reset asserted during TRIPPED or HOLDOFF, including mid-period.

Structure
REQ-030 SHALL take the state enum ovr_state_t and the default values of TRIP_PERIODS, HARD_CYCLES and HOLDOFF_PERIODS from shared package ovr_i_pkg.
REQ-031 SHALL instantiate sub-module ovr_synch (two-flop synchronizer, rst-cleared) once per side.

Verification
REQ-032 SHALL cover: OVR_I_lft high only inside ovr_I_blank, for 45 cycles in each of 10 periods -> OVR_I_shtdwn stays 0.
REQ-033 SHALL cover: OVR_I_lft pulses of 3 cycles outside blank in 4 consecutive periods -> shutdown asserts the cycle after the 4th PWM_synch evaluation; ovr_src=2'b01.
REQ-034 SHALL cover: OVR_I_rght held 45 cycles outside blank -> shutdown asserts 2+32+1 cycles after the rising edge; ovr_src=2'b10.
REQ-035 SHALL cover: 3 qualified periods, then 1 clean period, then 3 qualified periods -> no trip.
REQ-036 SHALL cover: after a trip, clr with OVR_I_lft still high -> stays TRIPPED. Then drop the flag and clr -> shutdown held exactly 8 PWM periods, then deasserts; ovr_src=0.
REQ-037 SHALL cover: rst pulsed mid-HOLDOFF -> OVR_I_shtdwn=0 immediately, with no clk edge required.
